jtag_host_shifter: RTL
======================

Name: jtag_host_shifter

Overview:
- Command-driven JTAG initiator. It generates TCK, TMS and TDI, and samples TDO, to drive an external TAP.
- It is the host-side counterpart of the chip's JTAG/DMI responder pads. Uses: FPGA bring-up boards, and self-test of a second device over the DPS pins.
- Software or a test sequencer issues commands over a valid/ready channel. Captured TDO bits return on a response channel.

Parameters:
- ClkDiv, 4, TCK half-period in clk_i cycles. Must be >= 1.
- MaxLen, 32, maximum bits per command. Also the width of the TMS/TDI/TDO vectors.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_op_i  in  2  0=TMS_SEQ, 1=SHIFT, 2=TRST_PULSE, 3=SRST_PULSE
- cmd_len_i  in  $clog2(MaxLen)+1  bit count
- cmd_tms_i  in  MaxLen  TMS bits for TMS_SEQ, LSB first
- cmd_tdi_i  in  MaxLen  TDI bits for SHIFT, LSB first
- cmd_last_i  in  1  SHIFT only: drive TMS=1 on the final bit (exit Shift-xR)
- rsp_valid_o  out  1  response valid (SHIFT only)
- rsp_ready_i  in  1  response accepted
- rsp_tdo_o  out  MaxLen  captured TDO, LSB = first bit
- jtag_tck_o  out  1  TCK
- jtag_tms_o  out  1  TMS
- jtag_tdi_o  out  1  TDI
- jtag_tdo_i  in  1  TDO from target
- jtag_trst_no  out  1  TAP reset, active-low
- jtag_srst_no  out  1  system reset, active-low

Behaviour:
- Reset values:
  - tck=0, tms=1 (keeps target TAP in Test-Logic-Reset), tdi=0, trst_no=1, srst_no=1.
  - cmd_ready_o=0 while rst_ni is low, then 1 in IDLE.
  - rsp_valid_o=0, rsp_tdo_o=0.
- FSM states: IDLE, TCK_LO, TCK_HI, PULSE, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On valid&ready (cycle N), latch the command; bit index i=0.
  - Clamp length: len>MaxLen is treated as MaxLen.
- Zero-length commands:
  - len==0 with SHIFT -> go to RESP next cycle with tdo=0. No TCK edge.
  - len==0 with TMS_SEQ -> return to IDLE. No effect.
- TCK_LO:
  - Entered at cycle N+1 with tck=0.
  - tms/tdi are registered at entry of the phase, so they are stable a full half-period before the rising edge.
  - TMS_SEQ: tms=cmd_tms[i], tdi=0.
  - SHIFT: tdi=cmd_tdi[i]; tms=(i==len-1)?cmd_last:0.
  - After ClkDiv cycles -> TCK_HI.
- TCK_HI:
  - tck=1.
  - On the entry cycle, sample jtag_tdo_i into tdo[i] (rising-edge capture).
  - After ClkDiv cycles: tck=0. If i==len-1, go to RESP (SHIFT) or IDLE (TMS_SEQ); otherwise i++ and go to TCK_LO.
- Timing:
  - One bit = 2*ClkDiv cycles.
  - The last TCK falling edge is at N+1+2*ClkDiv*len.
  - rsp_valid_o rises on that same cycle.
- Outputs between commands:
  - tms and tdi hold their last driven values in IDLE.
  - tck is always 0 in IDLE and RESP.
- RESP:
  - rsp_valid_o=1 and rsp_tdo_o stable until rsp_ready_i. Unused upper bits are 0.
  - cmd_ready_o=0.
  - On the handshake -> IDLE, and cmd_ready_o=1 the following cycle.
- PULSE (TRST_PULSE / SRST_PULSE):
  - Drive the selected reset low for 2*ClkDiv cycles, with tck=0 and tms=1.
  - Then release the reset and go to IDLE. No response.
- Back-pressure: cmd_ready_o is 0 in every non-IDLE state. Only one command is in flight.
- Async reset mid-operation: all outputs return to reset values immediately. The in-flight command is dropped and no response is issued after release.
- Counters:
  - Phase counter width is $clog2(ClkDiv+1) and saturates at ClkDiv.
  - Bit index width is $clog2(MaxLen); no wrap is possible because of the clamp.

Decomposition:
- jtag_host_pkg:
  - op enum (TMS_SEQ, SHIFT, TRST_PULSE, SRST_PULSE)
  - FSM state enum
  - localparam LenW = $clog2(MaxLen)+1
- One sub-module, jtag_host_tck_gen:
  - ClkDiv phase counter.
  - Emits a one-cycle rise_strobe (TCK_LO->TCK_HI) and fall_strobe (TCK_HI->TCK_LO/done).
  - Registered tck output.
  - Controlled by an enable from the main FSM.

Test Plan:
1. ClkDiv=2, TMS_SEQ, len=5, tms=5'b11111 -> 5 TCK pulses of period 4 cycles; tms=1 throughout; no rsp; cmd_ready_o returns at N+1+20+1.
2. SHIFT, len=8, tdi=0xA5, last=1, tdo looped from tdi -> rsp_tdo=0x000000A5; tms=1 only during the 8th bit; rsp_valid at N+1+16*ClkDiv.
3. SHIFT, len=32, tdi=0xDEADBEEF, tdo tied 1, rsp_ready held low 10 cycles -> rsp_tdo=0xFFFFFFFF stable; cmd_ready_o=0 until the handshake.
4. SHIFT, len=0 -> no TCK edge; rsp_valid at N+1 with rsp_tdo=0. Len=40 -> exactly 32 TCK pulses.
5. TRST_PULSE then SRST_PULSE -> each reset low for exactly 2*ClkDiv cycles; tck=0; the other reset stays 1.
6. rst_ni asserted during bit 3 of a SHIFT -> tck=0, tms=1 within the same cycle; after release, no rsp_valid and cmd_ready_o=1.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// Shared types for the JTAG host shifter: command opcodes, FSM states and
// the default command-length width.
package jtag_host_pkg;

   typedef enum logic [1:0] {
      OP_TMS_SEQ    = 2'd0,
      OP_SHIFT      = 2'd1,
      OP_TRST_PULSE = 2'd2,
      OP_SRST_PULSE = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TCK_LO,
      ST_TCK_HI,
      ST_PULSE,
      ST_RESP
   } state_e;

   localparam int unsigned DefaultMaxLen = 32;
   localparam int unsigned LenW          = $clog2(DefaultMaxLen) + 1;

endpackage

// File: rtl/jtag_host_tck_gen.sv
// TCK phase timer: ClkDiv cycles per half-period, one-cycle rise/fall strobes
// on the last cycle of each phase, and a registered (maskable) TCK output.
module jtag_host_tck_gen #(
   parameter int unsigned ClkDiv = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic mask,
   output logic rise_strobe,
   output logic fall_strobe,
   output logic tck
);

   localparam int unsigned CntW = $clog2(ClkDiv + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(ClkDiv - 1);
   localparam logic [CntW-1:0] SatCnt  = CntW'(ClkDiv);

   logic [CntW-1:0] cnt;
   logic            level;
   logic            phase_end;

   assign phase_end   = en && (cnt == LastCnt);
   assign rise_strobe = phase_end && !level;
   assign fall_strobe = phase_end && level;

   // level tracks the logical phase even when masked, so pulses reuse the timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
         tck   <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         level <= 1'b0;
         tck   <= 1'b0;
      end else if (phase_end) begin
         cnt   <= '0;
         level <= !level;
         tck   <= !level && !mask;
      end else if (cnt != SatCnt) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/jtag_host_shifter.sv
// Command-driven JTAG initiator: TMS sequences, TDI/TDO shifts and TRST/SRST
// pulses, with captured TDO returned on a valid/ready response channel.
module jtag_host_shifter
   import jtag_host_pkg::*;
#(
   parameter int unsigned ClkDiv = 4,
   parameter int unsigned MaxLen = DefaultMaxLen
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [1:0]              cmd_op_i,
   input  logic [$clog2(MaxLen):0] cmd_len_i,
   input  logic [MaxLen-1:0]       cmd_tms_i,
   input  logic [MaxLen-1:0]       cmd_tdi_i,
   input  logic                    cmd_last_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [MaxLen-1:0]       rsp_tdo_o,
   output logic                    jtag_tck_o,
   output logic                    jtag_tms_o,
   output logic                    jtag_tdi_o,
   input  logic                    jtag_tdo_i,
   output logic                    jtag_trst_no,
   output logic                    jtag_srst_no
);

   localparam int unsigned IdxW    = $clog2(MaxLen);
   localparam int unsigned CmdLenW = $clog2(MaxLen) + 1;
   localparam logic [CmdLenW-1:0] MaxLenL = CmdLenW'(MaxLen);
   localparam logic [CmdLenW-1:0] OneL    = CmdLenW'(1);

   state_e              state;
   op_e                 op;
   logic [MaxLen-1:0]   tms_vec;
   logic [MaxLen-1:0]   tdi_vec;
   logic [MaxLen-1:0]   tdo_vec;
   logic                last_flag;
   logic [IdxW-1:0]     idx;
   logic [IdxW-1:0]     idx_next;
   logic [IdxW-1:0]     last_idx;
   logic [CmdLenW-1:0]  len_eff;
   logic                accept;
   logic                hi_entry;
   logic                gen_en;
   logic                gen_mask;
   logic                rise;
   logic                fall;

   assign len_eff   = (cmd_len_i > MaxLenL) ? MaxLenL : cmd_len_i;
   assign accept    = (state == ST_IDLE) && cmd_ready_o && cmd_valid_i;
   assign idx_next  = idx + 1'b1;
   assign gen_en    = (state == ST_TCK_LO) || (state == ST_TCK_HI) || (state == ST_PULSE);
   assign gen_mask  = (state == ST_PULSE);
   assign rsp_tdo_o = tdo_vec;

   jtag_host_tck_gen #(
      .ClkDiv(ClkDiv)
   ) u_tck_gen (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .en         (gen_en),
      .mask       (gen_mask),
      .rise_strobe(rise),
      .fall_strobe(fall),
      .tck        (jtag_tck_o)
   );

   always_ff @(posedge clk_i) begin
      if (accept) begin
         tms_vec   <= cmd_tms_i;
         tdi_vec   <= cmd_tdi_i;
         last_flag <= cmd_last_i;
         last_idx  <= IdxW'(len_eff - OneL);
      end
   end

   // cmd_ready_o lags entry into IDLE by one cycle except after a response handshake
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= ST_IDLE;
         op           <= OP_TMS_SEQ;
         idx          <= '0;
         hi_entry     <= 1'b0;
         tdo_vec      <= '0;
         cmd_ready_o  <= 1'b0;
         rsp_valid_o  <= 1'b0;
         jtag_tms_o   <= 1'b1;
         jtag_tdi_o   <= 1'b0;
         jtag_trst_no <= 1'b1;
         jtag_srst_no <= 1'b1;
      end else begin
         hi_entry <= rise && (state == ST_TCK_LO);
         case (state)
            ST_IDLE: begin
               if (!cmd_ready_o) begin
                  cmd_ready_o <= 1'b1;
               end else if (cmd_valid_i) begin
                  cmd_ready_o <= 1'b0;
                  op          <= op_e'(cmd_op_i);
                  idx         <= '0;
                  tdo_vec     <= '0;
                  case (op_e'(cmd_op_i))
                     OP_TMS_SEQ: begin
                        if (len_eff != '0) begin
                           state      <= ST_TCK_LO;
                           jtag_tms_o <= cmd_tms_i[0];
                           jtag_tdi_o <= 1'b0;
                        end
                     end
                     OP_SHIFT: begin
                        if (len_eff == '0) begin
                           state       <= ST_RESP;
                           rsp_valid_o <= 1'b1;
                        end else begin
                           state      <= ST_TCK_LO;
                           jtag_tdi_o <= cmd_tdi_i[0];
                           jtag_tms_o <= (len_eff == OneL) ? cmd_last_i : 1'b0;
                        end
                     end
                     OP_TRST_PULSE: begin
                        state        <= ST_PULSE;
                        jtag_tms_o   <= 1'b1;
                        jtag_trst_no <= 1'b0;
                     end
                     OP_SRST_PULSE: begin
                        state        <= ST_PULSE;
                        jtag_tms_o   <= 1'b1;
                        jtag_srst_no <= 1'b0;
                     end
                     default: state <= ST_IDLE;
                  endcase
               end
            end
            ST_TCK_LO: begin
               if (rise) state <= ST_TCK_HI;
            end
            ST_TCK_HI: begin
               if (hi_entry) tdo_vec[idx] <= jtag_tdo_i;
               if (fall) begin
                  if (idx == last_idx) begin
                     if (op == OP_SHIFT) begin
                        state       <= ST_RESP;
                        rsp_valid_o <= 1'b1;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     idx   <= idx_next;
                     state <= ST_TCK_LO;
                     if (op == OP_SHIFT) begin
                        jtag_tdi_o <= tdi_vec[idx_next];
                        jtag_tms_o <= (idx_next == last_idx) ? last_flag : 1'b0;
                     end else begin
                        jtag_tms_o <= tms_vec[idx_next];
                        jtag_tdi_o <= 1'b0;
                     end
                  end
               end
            end
            ST_PULSE: begin
               if (fall) begin
                  jtag_trst_no <= 1'b1;
                  jtag_srst_no <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
